// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// bus direction codes, requester identifiers and data-window address mapping.
package mem_port_arbiter_pkg;

  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam logic [7:0] ABORT_RDATA = 8'hFF;

  // The data window is 256 bytes; the offset replaces the low byte, so it never carries into the base.
  function automatic logic [15:0] window_addr(input logic [7:0] base_hi, input logic [7:0] offset);
    return {base_hi, offset};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled with a view
// for the arbiter (slave) and one for its surroundings (master).
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [7:0]  i_rdata;
  logic        d_req;
  logic        d_dir;
  logic [7:0]  d_addr;
  logic [7:0]  d_wdata;
  logic        d_ack;
  logic [7:0]  d_rdata;
  logic        m_req;
  logic        m_dir;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_ack;
  logic [7:0]  m_rdata;
  logic        err;
  logic        err_clr;

  modport slave (
    input  i_req, i_addr, d_req, d_dir, d_addr, d_wdata, m_ack, m_rdata, err_clr,
    output i_ack, i_rdata, d_ack, d_rdata, m_req, m_dir, m_addr, m_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_dir, d_addr, d_wdata, m_ack, m_rdata, err_clr,
    input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_dir, m_addr, m_wdata, err
  );

endinterface

// File: rtl/mem_port_arbiter_bus_timeout_ctr.sv
// Counts memory wait cycles of the current transaction and flags the cycle
// in which the count would reach TIMEOUT without a memory acknowledge.
module bus_timeout_ctr #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_r;

  // Wait-cycle counter, restarted on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable) begin
      count_r <= count_r + 8'd1;
    end
  end

  // enable is only true on cycles without m_ack, so an acknowledge on the last allowed cycle still wins.
  assign expired = enable && ((count_r + 8'd1) == TIMEOUT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction
// fetch port and a data port mapped into a 256-byte window.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [15:0] D_BASE  = 16'h8000,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        owner_r;
  logic        last_grant_r;
  logic        grant_i_s;
  logic        grant_d_s;
  logic        busy_s;
  logic        done_s;
  logic        expired_s;
  logic        ctr_en_s;
  logic        m_req_r;
  logic        m_dir_r;
  logic [15:0] m_addr_r;
  logic [7:0]  m_wdata_r;
  logic        i_ack_r;
  logic        d_ack_r;
  logic [7:0]  i_rdata_r;
  logic [7:0]  d_rdata_r;
  logic        err_r;

  assign busy_s   = (state_r == ST_BUSY_I) || (state_r == ST_BUSY_D);
  assign done_s   = busy_s && bus.m_ack;
  assign ctr_en_s = busy_s && !bus.m_ack;

  // Grant selection: contention goes to the port that did not win last time.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (bus.i_req && bus.d_req) begin
        if (last_grant_r == OWNER_D) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b1;
        end
      end else begin
        grant_i_s = bus.i_req;
        grant_d_s = bus.d_req;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_i_s) begin
          state_nxt_s = ST_BUSY_I;
        end else if (grant_d_s) begin
          state_nxt_s = ST_BUSY_D;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (done_s || expired_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, current owner and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWNER_I;
      last_grant_r <= OWNER_D;
    end else begin
      state_r <= state_nxt_s;
      if (grant_i_s) begin
        owner_r <= OWNER_I;
      end else if (grant_d_s) begin
        owner_r <= OWNER_D;
      end
      if (state_r == ST_RESP) begin
        last_grant_r <= owner_r;
      end
    end
  end

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_i_s || grant_d_s),
    .enable  (ctr_en_s),
    .expired (expired_s)
  );

  // Memory command latch at grant and completion/abort response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req_r   <= 1'b0;
      m_dir_r   <= DIRECTION_READ;
      m_addr_r  <= 16'h0000;
      m_wdata_r <= 8'h00;
      i_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      i_rdata_r <= 8'h00;
      d_rdata_r <= 8'h00;
    end else begin
      i_ack_r <= 1'b0;
      d_ack_r <= 1'b0;
      if (grant_i_s) begin
        m_req_r   <= 1'b1;
        m_dir_r   <= DIRECTION_READ;
        m_addr_r  <= bus.i_addr;
        m_wdata_r <= 8'h00;
      end else if (grant_d_s) begin
        m_req_r   <= 1'b1;
        m_dir_r   <= bus.d_dir;
        m_addr_r  <= window_addr(D_BASE[15:8], bus.d_addr);
        m_wdata_r <= bus.d_wdata;
      end else if (done_s || expired_s) begin
        m_req_r <= 1'b0;
        if (state_r == ST_BUSY_I) begin
          i_ack_r   <= 1'b1;
          i_rdata_r <= done_s ? bus.m_rdata : ABORT_RDATA;
        end else begin
          d_ack_r <= 1'b1;
          if (m_dir_r == DIRECTION_READ) begin
            d_rdata_r <= done_s ? bus.m_rdata : ABORT_RDATA;
          end
        end
      end
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (expired_s) begin
      err_r <= 1'b1;
    end else if (bus.err_clr) begin
      err_r <= 1'b0;
    end
  end

  assign bus.m_req   = m_req_r;
  assign bus.m_dir   = m_dir_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_wdata = m_wdata_r;
  assign bus.i_ack   = i_ack_r;
  assign bus.i_rdata = i_rdata_r;
  assign bus.d_ack   = d_ack_r;
  assign bus.d_rdata = d_rdata_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic [15:0] TB_D_BASE  = 16'h8000;
  localparam int          TB_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .D_BASE  (TB_D_BASE),
    .TIMEOUT (8'(TB_TIMEOUT))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder configuration
  int         wait_cfg = 0;
  logic [7:0] data_cfg = 8'h00;
  bit         wait_random = 1'b0;
  bit         data_random = 1'b0;
  bit         noise_en = 1'b0;
  int         wait_left = 0;
  logic [7:0] next_data = 8'h00;

  // Model state: one outstanding transaction record plus the expected outputs
  logic        exp_m_req, exp_m_dir, exp_i_ack, exp_d_ack, exp_err;
  logic [15:0] exp_m_addr;
  logic [7:0]  exp_m_wdata, exp_i_rdata, exp_d_rdata;
  bit          in_flight, resp_cycle, owner_d, last_d;
  int          waited;
  logic        i_ack_q = 1'b0;
  logic        d_ack_q = 1'b0;

  task automatic model_reset();
    exp_m_req = 1'b0; exp_m_dir = DIRECTION_READ; exp_m_addr = 16'h0000; exp_m_wdata = 8'h00;
    exp_i_ack = 1'b0; exp_d_ack = 1'b0; exp_i_rdata = 8'h00; exp_d_rdata = 8'h00; exp_err = 1'b0;
    in_flight = 1'b0; resp_cycle = 1'b0; waited = 0; owner_d = 1'b0; last_d = 1'b1;
  endtask

  task automatic model_finish(input bit aborted);
    logic [7:0] data;
    data = aborted ? 8'hFF : bus.m_rdata;
    in_flight = 1'b0;
    resp_cycle = 1'b1;
    exp_m_req = 1'b0;
    if (!owner_d) begin
      exp_i_ack = 1'b1;
      exp_i_rdata = data;
    end else begin
      exp_d_ack = 1'b1;
      if (exp_m_dir == DIRECTION_READ) exp_d_rdata = data;
    end
  endtask

  task automatic model_edge();
    bit aborted;
    aborted = 1'b0;
    exp_i_ack = 1'b0;
    exp_d_ack = 1'b0;
    if (resp_cycle) begin
      resp_cycle = 1'b0;
      last_d = owner_d;
    end else if (in_flight) begin
      if (bus.m_ack) begin
        model_finish(1'b0);
      end else begin
        waited++;
        if (waited == TB_TIMEOUT) begin
          aborted = 1'b1;
          model_finish(1'b1);
        end
      end
    end else if (bus.i_req || bus.d_req) begin
      owner_d = (bus.i_req && bus.d_req) ? !last_d : bus.d_req;
      in_flight = 1'b1;
      waited = 0;
      exp_m_req = 1'b1;
      if (owner_d) begin
        exp_m_dir = bus.d_dir;
        exp_m_addr = {TB_D_BASE[15:8], bus.d_addr};
        exp_m_wdata = bus.d_wdata;
      end else begin
        exp_m_dir = DIRECTION_READ;
        exp_m_addr = bus.i_addr;
      end
    end
    if (aborted) exp_err = 1'b1;
    else if (bus.err_clr) exp_err = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("m_req", 16'(bus.m_req), 16'(exp_m_req));
    if (rst || exp_m_req) begin
      chk("m_dir", 16'(bus.m_dir), 16'(exp_m_dir));
      chk("m_addr", bus.m_addr, exp_m_addr);
    end
    if (rst || (exp_m_req && exp_m_dir == DIRECTION_WRITE))
      chk("m_wdata", 16'(bus.m_wdata), 16'(exp_m_wdata));
    chk("i_ack", 16'(bus.i_ack), 16'(exp_i_ack));
    chk("d_ack", 16'(bus.d_ack), 16'(exp_d_ack));
    chk("i_rdata", 16'(bus.i_rdata), 16'(exp_i_rdata));
    chk("d_rdata", 16'(bus.d_rdata), 16'(exp_d_rdata));
    chk("err", 16'(bus.err), 16'(exp_err));
    chk("ack_overlap", 16'(bus.i_ack & bus.d_ack), 16'h0000);
    i_ack_q = bus.i_ack;
    d_ack_q = bus.d_ack;
  end

  // Memory: answers after a configurable number of wait cycles, optional stray acks while idle
  initial begin
    bus.m_ack = 1'b0;
    bus.m_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #3;
      if (bus.m_req) begin
        if (wait_left == 0) begin
          bus.m_ack = 1'b1;
          bus.m_rdata = next_data;
        end else begin
          bus.m_ack = 1'b0;
          bus.m_rdata = 8'($urandom);
          wait_left--;
        end
      end else begin
        bus.m_ack = noise_en && ($urandom_range(0, 3) == 0);
        bus.m_rdata = 8'($urandom);
        wait_left = wait_random ? int'($urandom_range(0, 5)) : wait_cfg;
        next_data = data_random ? 8'($urandom) : data_cfg;
      end
    end
  end

  task automatic clear_reqs();
    bus.i_req = 1'b0; bus.i_addr = 16'h0000; bus.d_req = 1'b0; bus.d_dir = DIRECTION_READ;
    bus.d_addr = 8'h00; bus.d_wdata = 8'h00; bus.err_clr = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #2;
    rst = 1'b1;
    clear_reqs();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  bit [3:0] order;
  int       n_acks;
  bit       seen;

  initial begin
    clear_reqs();
    data_cfg = 8'hA5;
    #1 rst = 1'b1;
    #1;
    chk("rst_m_req", 16'(bus.m_req), 16'h0000);
    chk("rst_m_addr", bus.m_addr, 16'h0000);
    chk("rst_i_rdata", 16'(bus.i_rdata), 16'h0000);
    chk("rst_err", 16'(bus.err), 16'h0000);
    step();
    rst = 1'b0;

    // Single fetch, zero-wait memory
    step();
    bus.i_req = 1'b1; bus.i_addr = 16'h0012;
    @(negedge clk); @(negedge clk);
    chk("fetch_m_req", 16'(bus.m_req), 16'h0001);
    chk("fetch_m_addr", bus.m_addr, 16'h0012);
    chk("fetch_m_dir", 16'(bus.m_dir), 16'(DIRECTION_READ));
    @(negedge clk);
    chk("fetch_i_ack", 16'(bus.i_ack), 16'h0001);
    chk("fetch_i_rdata", 16'(bus.i_rdata), 16'h00A5);
    step();
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("fetch_i_ack_pulse", 16'(bus.i_ack), 16'h0000);

    // Single data write into the window
    step();
    bus.d_req = 1'b1; bus.d_dir = DIRECTION_WRITE; bus.d_addr = 8'h34; bus.d_wdata = 8'h5A;
    @(negedge clk); @(negedge clk);
    chk("wr_m_addr", bus.m_addr, 16'h8034);
    chk("wr_m_dir", 16'(bus.m_dir), 16'(DIRECTION_WRITE));
    chk("wr_m_wdata", 16'(bus.m_wdata), 16'h005A);
    @(negedge clk);
    chk("wr_d_ack", 16'(bus.d_ack), 16'h0001);
    step();
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("wr_d_ack_pulse", 16'(bus.d_ack), 16'h0000);

    // Contention from reset, both ports re-requesting continuously
    reset_dut();
    bus.i_req = 1'b1; bus.i_addr = 16'h1234;
    bus.d_req = 1'b1; bus.d_dir = DIRECTION_READ; bus.d_addr = 8'h56;
    order = 4'b0000;
    n_acks = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (bus.i_ack && n_acks < 4) begin order[n_acks] = 1'b0; n_acks++; end
      if (bus.d_ack && n_acks < 4) begin order[n_acks] = 1'b1; n_acks++; end
    end
    chk("rr_ack_count", 16'(n_acks), 16'h0004);
    chk("rr_order", 16'(order), 16'h000A);
    step();
    clear_reqs();
    repeat (4) @(posedge clk);

    // Data read that never gets an acknowledge
    wait_cfg = 10;
    step();
    bus.d_req = 1'b1; bus.d_dir = DIRECTION_READ; bus.d_addr = 8'h10;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("to_busy_m_req", 16'(bus.m_req), 16'h0001);
    end
    @(negedge clk);
    chk("to_m_req_drop", 16'(bus.m_req), 16'h0000);
    chk("to_d_ack", 16'(bus.d_ack), 16'h0001);
    chk("to_d_rdata", 16'(bus.d_rdata), 16'h00FF);
    chk("to_err", 16'(bus.err), 16'h0001);
    step();
    bus.d_req = 1'b0; bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", 16'(bus.err), 16'h0000);

    // Acknowledge on the last allowed wait cycle
    wait_cfg = 3; data_cfg = 8'h3C;
    step();
    bus.d_req = 1'b1; bus.d_dir = DIRECTION_READ; bus.d_addr = 8'h20;
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("late_d_ack", 16'(bus.d_ack), 16'h0001);
    chk("late_d_rdata", 16'(bus.d_rdata), 16'h003C);
    chk("late_err", 16'(bus.err), 16'h0000);
    step();
    bus.d_req = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a waiting data read
    step();
    bus.d_req = 1'b1; bus.d_dir = DIRECTION_READ; bus.d_addr = 8'h77;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    bus.d_req = 1'b0;
    #1;
    chk("mid_rst_m_req", 16'(bus.m_req), 16'h0000);
    chk("mid_rst_m_addr", bus.m_addr, 16'h0000);
    chk("mid_rst_d_rdata", 16'(bus.d_rdata), 16'h0000);
    chk("mid_rst_d_ack", 16'(bus.d_ack), 16'h0000);
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_no_d_ack", 16'(bus.d_ack), 16'h0000);
    end
    wait_cfg = 0; data_cfg = 8'hC3;
    step();
    bus.i_req = 1'b1; bus.i_addr = 16'hABCD;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      seen = bus.i_ack;
    end
    chk("post_rst_fetch_ack", 16'(seen), 16'h0001);
    chk("post_rst_fetch_data", 16'(bus.i_rdata), 16'h00C3);
    step();
    bus.i_req = 1'b0;
    repeat (2) @(posedge clk);

    // Randomized traffic with random waits, stray acks, drops and clears
    wait_random = 1'b1; data_random = 1'b1; noise_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (bus.i_req && !i_ack_q) begin
        if ($urandom_range(0, 31) == 0) bus.i_req = 1'b0;
      end else begin
        bus.i_req = 1'($urandom_range(0, 1));
        bus.i_addr = 16'($urandom);
      end
      if (bus.d_req && !d_ack_q) begin
        if ($urandom_range(0, 31) == 0) bus.d_req = 1'b0;
      end else begin
        bus.d_req = 1'($urandom_range(0, 1));
        bus.d_dir = 1'($urandom_range(0, 1));
        bus.d_addr = 8'($urandom);
        bus.d_wdata = 8'($urandom);
      end
      bus.err_clr = ($urandom_range(0, 7) == 0);
    end
    step();
    clear_reqs();
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter D_BASE, default 16'h8000: memory base of the 256-byte data window; low byte ignored.
REQ-002 Parameter TIMEOUT, default 8'd255: maximum m_ack wait cycles before abort.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  instruction fetch request, held until i_ack.
REQ-006 i_addr  input  16  fetch address.
REQ-007 i_ack  output  1  one-cycle fetch completion pulse.
REQ-008 i_rdata  output  8  fetch data, valid with i_ack, held until next fetch completes.
REQ-009 d_req  input  1  data request, held until d_ack.
REQ-010 d_dir  input  1  DIRECTION_READ/DIRECTION_WRITE.
REQ-011 d_addr  input  8  data-window offset.
REQ-012 d_wdata  input  8  write data.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 d_rdata  output  8  read data, valid with d_ack, held until next data read completes.
REQ-015 m_req  output  1  shared single-port memory request.
REQ-016 m_dir  output  1  memory direction.
REQ-017 m_addr  output  16  memory address.
REQ-018 m_wdata  output  8  memory write data.
REQ-019 m_ack  input  1  memory completion, m_rdata valid same cycle.
REQ-020 m_rdata  input  8  memory read data.
REQ-021 err  output  1  sticky timeout flag.
REQ-022 err_clr  input  1  clears err.

Function
REQ-023 FSM states IDLE, BUSY_I, BUSY_D, RESP; exactly one requester owns the memory at a time.
REQ-024 IDLE: single req -> grant it; both -> grant port not granted last (round-robin); latch address/dir/wdata at grant edge.
REQ-025 BUSY_x: m_req=1, m_dir/m_addr/m_wdata stable from latched copy; fetch drives m_dir=READ, m_addr=i_addr.
REQ-026 Data mapping: m_addr = {D_BASE[15:8], d_addr}; no carry, offset wraps within window.
REQ-027 BUSY_x, m_ack=1 -> capture m_rdata (reads only), m_req=0, go RESP.
REQ-028 RESP: pulse owning ack for exactly one cycle, update last-grant, return to IDLE next edge.
REQ-029 Latency: zero-wait memory -> ack high in cycle starting two edges after req first sampled; throughput one transfer per 3 cycles.
REQ-030 Requester drops or replaces req on edge where ack is seen; IDLE after RESP samples fresh req.
REQ-031 req deasserted mid-BUSY: transaction still completes and acks; no cancellation.
REQ-032 Wait counter 8-bit, cleared at grant, increments each BUSY cycle without m_ack; reaching TIMEOUT -> m_req=0, err=1, go RESP, ack with rdata 8'hFF (reads), write discarded.
REQ-033 m_ack on same cycle counter reaches TIMEOUT: m_ack wins, no error.
REQ-034 err_clr and new timeout same cycle: set wins.
REQ-035 m_ack outside BUSY ignored.

Reset
REQ-036 rst asynchronously forces IDLE, m_req=0, m_dir=READ, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, err=0, counter=0, last-grant=D (fetch wins first contention).
REQ-037 rst mid-BUSY abandons transaction silently; no ack issued after release.

Structure
REQ-038 DIRECTION_READ/DIRECTION_WRITE come from the shared direction definitions; FSM state encodings local.
REQ-039 Wait counter with TIMEOUT compare is sub-module bus_timeout_ctr (clear, enable, expired).

Verification
REQ-040 i_req only, i_addr=16'h0012, zero-wait m_rdata=8'hA5 -> m_addr=16'h0012, i_ack one cycle, i_rdata=8'hA5, two edges after req.
REQ-041 d_req write, d_addr=8'h34, d_wdata=8'h5A, D_BASE=16'h8000 -> m_addr=16'h8034, m_dir=WRITE, m_wdata=8'h5A, d_ack one pulse.
REQ-042 i_req and d_req together from reset, both re-requested continuously -> grant order I,D,I,D; no overlapping acks.
REQ-043 m_ack held low, TIMEOUT=4, d read -> m_req drops after 4 BUSY cycles, d_ack pulse, d_rdata=8'hFF, err=1; err_clr pulse -> err=0.
REQ-044 rst asserted during BUSY_D with 3-cycle memory wait -> outputs immediately at reset values, no d_ack after release; next i_req served normally.
REQ-045 m_ack on exactly TIMEOUT cycle with m_rdata=8'h3C -> rdata 8'h3C, err stays 0.
